counter_16bit_sched: RTL and testbench

Round-robin scheduler that time-shares one 16-bit up counter (synchronous active-high clear, enable input, 16-bit count output) among NUM_REQ requesters. Each requester asks for an interval of N clock cycles. The scheduler grants one requester at a time, clears and enables the shared counter, and watches its count. When N cycles have elapsed it pulses that requester's done. It sits between timing clients (e.g. debounce, timeout, PWM blocks) and the single counter instance.

---
 rtl/counter_16bit_sched.sv | 147 ++++++++++++++
 tb/tb_counter_16bit_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_16bit_sched.sv
// counter_16bit_sched
//
// Round-robin scheduler that time-shares one 16-bit up counter among NUM_REQ
// requesters. A granted requester has the counter cleared (ARM) and then
// enabled (RUN) until the count equals its requested length. The scheduler
// then pulses that requester's done for one cycle (DONE). Dropping req while
// granted abandons the interval without a done pulse.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   reset      synchronous active-low reset
//   req        per-requester request level
//   req_len    per-requester interval length, slice i = [16*i+15:16*i]
//   cnt_count  count value of the shared counter
//   cnt_clear  active-high clear to the counter (high during ARM)
//   cnt_enable count enable to the counter (combinational from cnt_count)
//   grant      one-hot owner, zero when idle
//   done       one-hot, one-cycle pulse on interval completion
//   busy       high in any state except idle

module counter_16bit_sched #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_len,
    input  logic [15:0]             cnt_count,
    output logic                    cnt_clear,
    output logic                    cnt_enable,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun,
        StDone
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               clear_q;
    logic               busy_q;
    logic [15:0]        len_q;
    logic [PtrW-1:0]    rr_q;

    logic               pick_found;
    logic [PtrW-1:0]    pick_idx;
    logic [PtrW-1:0]    rr_next;
    logic [15:0]        len_pick;
    logic               owner_req;

    // Winner search: first set request at or above the rr pointer, wrapping.
    // Walking offsets downward lets the smallest offset overwrite the rest.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % int'(NUM_REQ);
            if (req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PtrW'(idx);
            end
        end
    end

    always_comb begin
        len_pick = req_len[16*int'(pick_idx) +: 16];
        rr_next  = (pick_idx == PtrW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    // The owner still wants its interval; low means abandon.
    assign owner_req = |(req & grant_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= '0;
            rr_q    <= '0;
        end else begin
            done_q  <= '0;
            clear_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        len_q   <= len_pick;
                        rr_q    <= rr_next;
                        clear_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (!owner_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!owner_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_count == len_q) begin
                        done_q  <= grant_q;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Only path from an input to an output: stop counting exactly at len_q,
    // and immediately on abandon.
    assign cnt_enable = (state_q == StRun) && owner_req && (cnt_count != len_q);
    assign cnt_clear  = clear_q;
    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_counter_16bit_sched.sv
module tb_counter_16bit_sched;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [16*NR-1:0]  req_len;
    logic [15:0]       ctr = '0;
    logic              cnt_clear;
    logic              cnt_enable;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 idle), cycles since grant, sampled length, rr pointer.
    int m_owner = -1;
    int m_t     = 0;
    int m_n     = 0;
    int m_rr    = 0;
    bit autodrop = 1'b0;

    counter_16bit_sched #(.NUM_REQ(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_len    (req_len),
        .cnt_count  (ctr),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .grant      (grant),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // The shared counter the scheduler drives.
    always @(posedge clk) begin
        if (cnt_clear) ctr <= '0;
        else if (cnt_enable) ctr <= ctr + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void set_len(input int i, input logic [15:0] v);
        req_len[16*i +: 16] = v;
    endfunction

    // Compare this cycle's outputs with the model, then advance one clock.
    task automatic step();
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        int fin;
        #1;
        eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
        ed = (m_owner >= 0 && m_t == m_n + 2) ? eg : '0;
        check("grant", 32'(grant), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("cnt_clear", 32'(cnt_clear), 32'(m_owner >= 0 && m_t == 0));
        check("cnt_enable", 32'(cnt_enable),
              32'(m_owner >= 0 && m_t >= 1 && m_t <= m_n && req[m_owner]));
        if (m_owner >= 0 && m_t >= 1 && m_t <= m_n + 2)
            check("cnt_count", 32'(ctr), 32'((m_t - 1 < m_n) ? m_t - 1 : m_n));

        fin = -1;
        if (!reset) begin
            m_owner = -1;
            m_rr    = 0;
        end else if (m_owner < 0) begin
            for (int off = 0; off < NR; off++) begin
                if (m_owner < 0 && req[(m_rr + off) % NR]) m_owner = (m_rr + off) % NR;
            end
            if (m_owner >= 0) begin
                m_t  = 0;
                m_n  = int'(req_len[16*m_owner +: 16]);
                m_rr = (m_owner + 1) % NR;
            end
        end else if (m_t == m_n + 2) begin
            fin     = m_owner;
            m_owner = -1;
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else begin
            m_t++;
        end
        @(posedge clk);
        #1;
        if (autodrop && fin >= 0) req[fin] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        req     = 4'b1111;
        req_len = '0;
        @(posedge clk);
        #1;

        // Reset held with all requests high, then first grant goes to requester 0.
        run(3);
        reset = 1'b1;
        for (int i = 0; i < NR; i++) set_len(i, 16'd3);
        step();
        check("first_grant", 32'(grant), 32'h1);
        req = 4'b0000;                  // abandon during ARM
        run(3);

        // Single interval, length 5 on requester 2.
        autodrop = 1'b1;
        set_len(2, 16'd5);
        req = 4'b0100;
        run(14);

        // Round robin, all lengths 2, requests dropped on done.
        do_reset();
        for (int i = 0; i < NR; i++) set_len(i, 16'd2);
        req = 4'b1111;
        run(28);
        req = 4'b1001;
        step();
        check("rr_1001_first", 32'(grant), 32'h1);
        run(14);

        // Zero length on requester 1.
        set_len(1, 16'd0);
        req = 4'b0010;
        run(8);

        // Abandon requester 0 at RUN cycle 10 while requester 1 waits.
        do_reset();
        set_len(0, 16'd100);
        set_len(1, 16'd3);
        req = 4'b0011;
        for (int k = 0; k < 40 && !(m_owner == 0 && m_t == 10); k++) step();
        req = 4'b0010;
        step();
        check("abandon_enable", 32'(cnt_enable), 32'h0);
        step();
        check("abandon_grant1", 32'(grant), 32'h2);
        run(10);

        // Maximum length runs to FFFF and the counter holds there.
        do_reset();
        set_len(3, 16'hFFFF);
        req = 4'b1000;
        for (int k = 0; k < 70000 && req != 4'b0000; k++) step();
        run(2);
        check("max_hold", 32'(ctr), 32'h0000FFFF);

        // Repeat, reset mid-RUN, next grant must re-clear the counter.
        autodrop = 1'b0;
        req = 4'b1000;
        for (int k = 0; k < 300 && !(m_owner == 3 && m_t == 200); k++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset_busy", 32'(busy), 32'h0);
        run(8);
        req = 4'b0000;
        run(3);

        // Randomised traffic with occasional resets and length changes.
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
                if ($urandom_range(7) == 0) set_len(i, 16'($urandom_range(12)));
            end
            reset = ($urandom_range(499) != 0);
            step();
        end
        reset = 1'b1;
        req = '0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
